// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store path.
// Accepts one word transaction through a req/ack handshake, inserts LATENCY
// wait states, then performs the store or load. A misaligned or out-of-range
// address is answered with err=1 and touches neither memory nor rd.
//
// Ports:
//   clock  - system clock, all state changes on the rising edge
//   reset  - synchronous, active-high; memory contents are kept
//   req    - transaction request, sampled only while idle
//   we     - 1 = store, 0 = load (captured with req)
//   addr   - byte address (captured with req)
//   wd     - store data (captured with req)
//   rd     - load data, valid with ack and held afterwards
//   ack    - one-cycle completion pulse
//   err    - valid with ack; 1 = transaction rejected
//   busy   - high whenever a transaction is in flight
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            cap_we;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wd;

    logic [31:0]     mem [DEPTH];

    logic            req_valid_c;
    logic            access_c;
    logic            acc_we_c;
    logic [AW-1:0]   acc_idx_c;
    logic [31:0]     acc_wd_c;

    // Access source: live inputs for a zero-latency access taken straight
    // from IDLE, otherwise the fields captured when the request was accepted.
    always_comb begin
        req_valid_c = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
        access_c    = 1'b0;
        acc_we_c    = cap_we;
        acc_idx_c   = cap_idx;
        acc_wd_c    = cap_wd;
        case (state)
            IDLE: begin
                acc_we_c  = we;
                acc_idx_c = addr[AW+1:2];
                acc_wd_c  = wd;
                access_c  = req && req_valid_c && (LATENCY == 0);
            end
            WAIT: begin
                access_c = (cnt == CW'(1));
            end
            default: ;
        endcase
    end

    // Memory array; never cleared, and a reset edge blocks a pending store.
    always_ff @(posedge clock) begin
        if (!reset && access_c && acc_we_c) begin
            mem[acc_idx_c] <= acc_wd_c;
        end
    end

    // Handshake FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rd      <= '0;
            cap_we  <= 1'b0;
            cap_idx <= '0;
            cap_wd  <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (access_c && !acc_we_c) begin
                rd <= mem[acc_idx_c];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we  <= we;
                        cap_idx <= addr[AW+1:2];
                        cap_wd  <= wd;
                        busy    <= 1'b1;
                        if (!req_valid_c) begin
                            state <= RESP;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end else if (LATENCY == 0) begin
                            state <= RESP;
                            ack   <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    // Counter only counts down to zero, so LATENCY=15 cannot wrap.
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                        ack   <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the CPU datapath's load/store interface.
- Receives the datapath's address (ALU result), store data and write strobe through a req/ack handshake.
- Performs the word access after a programmable number of wait states and returns load data on rd.
- Replaces the ideal zero-latency data memory so the control unit can be tested against realistic, stalling memory.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, 2..4096
LATENCY, 2, wait cycles inserted before the access; 0..15

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
req    input  1  transaction request; sampled only in IDLE
we     input  1  1 = store, 0 = load; captured with req
addr   input  32  byte address; captured with req
wd     input  32  store data; captured with req
rd     output  32  load data; valid while ack=1, held afterwards
ack    output  1  one-cycle completion pulse
err    output  1  valid with ack; 1 = transaction rejected
busy   output  1  1 whenever state is not IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE, ack=0, err=0, busy=0, rd=0, wait counter=0.
  - Memory array is not cleared.
  - Reset mid-transaction aborts it; a store whose access edge has not yet occurred is not written.
- Word index = addr[log2(DEPTH)+1:2].
- Request is invalid if addr[1:0]!=0 (misaligned) or addr[31:log2(DEPTH)+2]!=0 (out of range).
- States:
  - IDLE: busy=0, ack=0.
    - On an edge with req=1: capture we/addr/wd and the valid/invalid decision.
    - Invalid -> RESP with err pending.
    - Valid, LATENCY=0 -> perform the access on this edge, go to RESP.
    - Valid, LATENCY>0 -> load counter=LATENCY, go to WAIT.
  - WAIT: decrement the counter each edge. On the edge where counter==1, perform the access and go to RESP.
  - RESP: ack=1 for exactly one cycle; err=1 if invalid, else 0. Next edge -> IDLE unconditionally.
- Access rules:
  - Store writes mem[index]=wd; rd unchanged.
  - Load registers mem[index] into rd.
  - Invalid transaction: no memory access; rd unchanged.
- Latency: if req is sampled at edge n, ack is high in the cycle following edge n+LATENCY. Handshake is LATENCY+1 cycles; a back-to-back transaction takes at least LATENCY+2 cycles.
- req is ignored in WAIT and RESP; captured inputs cannot change mid-transaction.
- The requester must drop req during the ack cycle, otherwise a new transaction starts at the first IDLE edge.
- Read-after-write: a load issued after a store's ack returns the stored value.
- err is cleared (0) in every non-RESP cycle.
- Counter is 4 bits; LATENCY=15 must not wrap.

Test Plan:
- Reset mid-WAIT: LATENCY=2, store 0x12345678 to 0x0000_0010, reset one cycle after req -> ack never pulses, busy=0 the cycle after reset; a later load of 0x10 returns the prior contents, not 0x12345678.
- Store then load: LATENCY=2, store 0xDEADBEEF to 0x0000_0008 -> ack 3 cycles after req, err=0. Load 0x08 -> rd=0xDEADBEEF with ack, held after ack drops.
- LATENCY=0 sweep: store idx*0x11 to every word 0..DEPTH-1, then load each -> ack each next cycle, all values match, busy high exactly one cycle per transaction.
- Misaligned and out-of-range: load 0x0000_0006 -> ack with err=1, rd unchanged. Store to 0x0000_0100 (DEPTH=64) -> err=1, memory unchanged.
- Held req: keep req=1 through ack with LATENCY=1 -> a second transaction starts the cycle after RESP. req toggled during WAIT is ignored, and addr/wd changes during WAIT do not affect the result.
- LATENCY=15: load -> ack exactly 16 cycles after the req edge, no counter wrap, single ack pulse.
